// File: rtl/prll_bs_pkg.sv
// Shared definitions for the parallel-bus arbiter: FSM states and field widths.
package prll_bs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    localparam int ID_W  = 8;
    localparam int GNT_W = 3;

endpackage

// File: rtl/rr_prio_sel.sv
// Round-robin priority select: first pending driver at or above rr_ptr, wrapping.
module rr_prio_sel
    import prll_bs_pkg::*;
#(
    parameter int drvrs = 4
) (
    input  logic [drvrs-1:0] pndng,
    input  logic [GNT_W-1:0] rr_ptr,
    output logic             valid,
    output logic [GNT_W-1:0] winner
);

    int unsigned idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            idx = (int'(rr_ptr) + i) % drvrs;
            if (!valid && pndng[idx]) begin
                valid  = 1'b1;
                winner = GNT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bs_rr_rbtr_ctrl.sv
// Round-robin bus arbiter: grants one driver, pops its head word and pushes it
// to the decoded destination RX FIFO(s); invalid destinations are counted.
module bs_rr_rbtr_ctrl
    import prll_bs_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              bits      = 32,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [drvrs-1:0]        pndng,
    input  logic [drvrs*bits-1:0]   D_pop,
    output logic [drvrs-1:0]        pop,
    output logic [drvrs-1:0]        push,
    output logic [bits-1:0]         D_push,
    output logic [GNT_W-1:0]        gnt_id,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

    state_t           state;
    logic [GNT_W-1:0] rr_ptr;
    logic             sel_valid;
    logic [GNT_W-1:0] sel_idx;
    logic [bits-1:0]  word;
    logic [ID_W-1:0]  dest;
    logic [drvrs-1:0] push_dec;
    logic             drop;

    rr_prio_sel #(
        .drvrs(drvrs)
    ) u_sel (
        .pndng (pndng),
        .rr_ptr(rr_ptr),
        .valid (sel_valid),
        .winner(sel_idx)
    );

    // Decode is done on the word being captured so push can be registered
    // on the same edge that loads the bus register.
    always_comb begin
        word     = D_pop[int'(gnt_id)*bits +: bits];
        dest     = word[bits-1 -: ID_W];
        push_dec = '0;
        drop     = 1'b0;
        if (dest == broadcast) begin
            push_dec = ~(ONE << gnt_id);
        end else if (dest < ID_W'(drvrs)) begin
            push_dec = ONE << dest;
        end else begin
            drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pop  <= '0;
            push <= '0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        gnt_id <= sel_idx;
                        pop    <= ONE << sel_idx;
                        busy   <= 1'b1;
                        state  <= POP;
                    end
                end
                POP: begin
                    D_push <= word;
                    push   <= push_dec;
                    if (drop && drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                    state <= PUSH;
                end
                PUSH: begin
                    rr_ptr <= (gnt_id == GNT_W'(drvrs - 1)) ? '0 : gnt_id + GNT_W'(1);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_rr_rbtr_ctrl.sv
// Directed bench for bs_rr_rbtr_ctrl: a transfer vector table plus corner sequences.
module tb_bs_rr_rbtr_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   pndng;
    logic [127:0] d_pop;
    logic [3:0]   pop;
    logic [3:0]   push;
    logic [31:0]  d_push;
    logic [2:0]   gnt_id;
    logic         busy;
    logic [7:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    bs_rr_rbtr_ctrl #(
        .drvrs    (4),
        .bits     (32),
        .broadcast(8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng),
        .D_pop   (d_pop),
        .pop     (pop),
        .push    (push),
        .D_push  (d_push),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   pndng;
        logic [127:0] d_pop;
        logic [3:0]   e_pop;
        logic [2:0]   e_gnt;
        logic [3:0]   e_push;
        logic [31:0]  e_word;
        logic [7:0]   e_drop;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pndng = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        pndng = v.pndng;
        d_pop = v.d_pop;
        step();
        chk($sformatf("v%0d pop", n), 32'(pop), 32'(v.e_pop));
        chk($sformatf("v%0d gnt", n), 32'(gnt_id), 32'(v.e_gnt));
        chk($sformatf("v%0d busy_pop", n), 32'(busy), 32'd1);
        chk($sformatf("v%0d push_in_pop", n), 32'(push), 32'd0);
        pndng = '0;
        step();
        chk($sformatf("v%0d push", n), 32'(push), 32'(v.e_push));
        chk($sformatf("v%0d d_push", n), d_push, v.e_word);
        chk($sformatf("v%0d pop_in_push", n), 32'(pop), 32'd0);
        chk($sformatf("v%0d busy_push", n), 32'(busy), 32'd1);
        step();
        chk($sformatf("v%0d busy_idle", n), 32'(busy), 32'd0);
        chk($sformatf("v%0d push_idle", n), 32'(push), 32'd0);
        chk($sformatf("v%0d d_push_hold", n), d_push, v.e_word);
        chk($sformatf("v%0d drop", n), 32'(drop_cnt), 32'(v.e_drop));
    endtask

    initial begin
        int pop_cnt;
        int last_pop;
        logic [3:0] exp_order [5];

        // d_pop is {word3, word2, word1, word0}; rr_ptr evolves across rows
        vecs[0] = '{4'b0100, {32'h0, 32'h0100ABCD, 32'h0, 32'h0},        4'b0100, 3'd2, 4'b0010, 32'h0100ABCD, 8'd0};
        vecs[1] = '{4'b0010, {32'h0, 32'h0, 32'hFF001234, 32'h0},        4'b0010, 3'd1, 4'b1101, 32'hFF001234, 8'd0};
        vecs[2] = '{4'b1000, {32'h05000000, 32'h0, 32'h0, 32'h0},        4'b1000, 3'd3, 4'b0000, 32'h05000000, 8'd1};
        vecs[3] = '{4'b1010, {32'h0A0A0A0A, 32'h0, 32'h03005555, 32'h0}, 4'b0010, 3'd1, 4'b1000, 32'h03005555, 8'd1};
        vecs[4] = '{4'b1011, {32'h03007777, 32'h0, 32'h0, 32'h00000001}, 4'b1000, 3'd3, 4'b1000, 32'h03007777, 8'd1};
        vecs[5] = '{4'b0011, {32'h0, 32'h0, 32'h01000000, 32'hFF000001}, 4'b0001, 3'd0, 4'b1110, 32'hFF000001, 8'd1};
        vecs[6] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h00000042},        4'b0001, 3'd0, 4'b0001, 32'h00000042, 8'd1};
        vecs[7] = '{4'b0100, {32'h0, 32'h80000000, 32'h0, 32'h0},        4'b0100, 3'd2, 4'b0000, 32'h80000000, 8'd2};

        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        step();
        step();
        chk("rst pop", 32'(pop), 32'd0);
        chk("rst push", 32'(push), 32'd0);
        chk("rst d_push", d_push, 32'd0);
        chk("rst gnt", 32'(gnt_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst drop", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        step();
        chk("idle no pending", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // All drivers pending continuously: grants 0,1,2,3,0 three cycles apart
        do_reset();
        d_pop = {32'h00000003, 32'h00000002, 32'h00000001, 32'h00000000};
        pndng = 4'b1111;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        pop_cnt  = 0;
        last_pop = -10;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (pop != 4'b0000) begin
                if (pop_cnt < 5) begin
                    chk($sformatf("rr order %0d", pop_cnt), 32'(pop), 32'(exp_order[pop_cnt]));
                end
                chk($sformatf("rr gap %0d", pop_cnt), 32'(c - last_pop >= 3), 32'd1);
                last_pop = c;
                pop_cnt++;
            end
        end
        chk("rr pop count", 32'(pop_cnt), 32'd5);
        pndng = '0;
        step();
        step();
        step();

        // Driver 0 drops pndng during PUSH; its transfer completes, then driver 3
        do_reset();
        d_pop = {32'h01000000, 32'h0, 32'h0, 32'h02000000};
        pndng = 4'b1001;
        step();
        chk("deassert gnt0", 32'(gnt_id), 32'd0);
        step();
        pndng = 4'b1000;
        chk("deassert push", 32'(push), 32'b0100);
        chk("deassert d_push", d_push, 32'h02000000);
        step();
        chk("deassert idle", 32'(busy), 32'd0);
        step();
        chk("deassert next pop", 32'(pop), 32'b1000);
        chk("deassert next gnt", 32'(gnt_id), 32'd3);
        pndng = '0;
        step();
        chk("deassert next push", 32'(push), 32'b0010);
        step();

        // Reset during POP: no push, rr_ptr back to 0
        do_reset();
        d_pop = {32'h00000000, 32'h0, 32'h03000000, 32'h01000000};
        vecs[0] = '{4'b0010, d_pop, 4'b0010, 3'd1, 4'b1000, 32'h03000000, 8'd0};
        run_vec(8, vecs[0]);
        pndng = 4'b1001;
        step();
        chk("rstpop gnt3", 32'(gnt_id), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstpop pop", 32'(pop), 32'd0);
        chk("rstpop push", 32'(push), 32'd0);
        chk("rstpop busy", 32'(busy), 32'd0);
        step();
        chk("rstpop regrant pop", 32'(pop), 32'b0001);
        chk("rstpop regrant gnt", 32'(gnt_id), 32'd0);
        pndng = '0;
        step();
        chk("rstpop regrant push", 32'(push), 32'b0010);
        step();

        // Drop counter saturation
        do_reset();
        d_pop = {32'h05000000, 32'h0, 32'h0, 32'h0};
        pndng = 4'b1000;
        for (int k = 0; k < 254 * 3; k++) begin
            step();
            if (push != 4'b0000) begin
                chk("sat push", 32'(push), 32'd0);
            end
        end
        chk("drop 254", 32'(drop_cnt), 32'hFE);
        for (int k = 0; k < 6 * 3; k++) begin
            step();
        end
        chk("drop sat", 32'(drop_cnt), 32'hFF);
        pndng = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bs_rr_rbtr_ctrl.md
# bs_rr_rbtr_ctrl

Round-robin arbiter and transfer sequencer for the shared parallel bus that links the per-driver FIFOs of the interconnect. It watches each driver's pending flag and grants the bus to one driver at a time. It pops that driver's head word, decodes the destination ID in the word header, and pushes the word into the destination driver's receive FIFO, or into every other driver's FIFO for a broadcast. The block sits between the driver FIFO array and the bus wrapper. It replaces fixed-priority selection with fair, starvation-free sequencing.

## Interface
Parameters:
- drvrs, 4: number of drivers on the bus; legal range 2..8.
- bits, 32: word width; must be ≥ 16.
- broadcast, 8'hFF: destination ID value that means "all drivers except the source".

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- pndng  in  drvrs  per-driver "TX FIFO non-empty"; FIFOs are show-ahead, so D_pop is valid while pndng is high.
- D_pop  in  drvrs×bits  head word of each driver's TX FIFO.
- pop  out  drvrs  one-hot, one-cycle pop strobe to the granted TX FIFO.
- push  out  drvrs  one-cycle push strobes to the RX FIFOs; more than one bit is set for a broadcast.
- D_push  out  bits  bus word, common to all RX FIFOs.
- gnt_id  out  3  ID of the driver currently or last granted.
- busy  out  1  high whenever state ≠ IDLE.
- drop_cnt  out  8  saturating count of words dropped for an invalid destination.

## Operation
- Destination ID is D_pop[bits-1 -: 8], taken from the captured word.
- FSM states are IDLE, POP and PUSH.
- IDLE:
  - Select the first driver with pndng set, scanning upward from rr_ptr and wrapping modulo drvrs.
  - If any driver is pending, latch the winner in gnt_id and go to POP. Otherwise stay in IDLE.
- POP:
  - pop[gnt_id]=1.
  - Capture D_pop[gnt_id] into the bus register.
  - Go to PUSH.
- PUSH: drive D_push from the bus register and decode the destination:
  - Destination is broadcast: push = all ones with bit gnt_id cleared.
  - Destination is below drvrs: push = one-hot(destination). A driver may address itself.
  - Any other destination: push = 0, and drop_cnt increments, saturating at 8'hFF.
  - In every case, rr_ptr becomes (gnt_id+1) mod drvrs, and the FSM returns to IDLE.
- pop and push are Moore outputs decoded from the registered state. They never assert outside POP and PUSH respectively.
- pndng is ignored outside IDLE. A pndng change during POP or PUSH has no effect on the transfer in flight.
- Receive-side full flags are not checked; RX FIFO sizing is owned by the system level.

## Timing
- Cycle n: IDLE with a pndng bit set.
- Cycle n+1: POP; pop is high.
- Cycle n+2: PUSH; push and D_push are valid.
- Cycle n+3: IDLE again.
- Minimum is 3 cycles per word; sustained throughput is 1 word per 3 cycles.
- D_push holds its last value outside PUSH.
- Reset values: state=IDLE, rr_ptr=0, gnt_id=0, pop=0, push=0, D_push=0, busy=0, drop_cnt=0.
- Reset asserted during POP or PUSH:
  - The FSM goes to IDLE on the next edge, and no push is issued.
  - A word already popped is lost and is not re-popped.
- Reset has priority over every other transition.
- rr_ptr wraps from drvrs-1 to 0.
- With every driver continuously pending, the grant order is 0,1,…,drvrs-1,0,…

## Structure
- A shared package prll_bs_pkg holds:
  - the state enum (IDLE, POP, PUSH);
  - the ID field width constant (8);
  - the gnt_id width constant (3).
- One combinational sub-module, rr_prio_sel, takes pndng and rr_ptr and returns valid plus winner index.
- The FSM, bus register, destination decode and drop counter live in the top level.

## Test plan
- Only driver 2 pending, word 32'h0100_ABCD:
  - pop[2] pulses at n+1.
  - push=4'b0010 and D_push=32'h0100_ABCD at n+2.
  - busy is high for exactly 2 cycles.
- All four drivers continuously pending, each with destination 0:
  - Grants go 0,1,2,3,0 across 15 cycles.
  - No two pops are closer than 3 cycles.
- Driver 1 sends destination 8'hFF: push=4'b1101 in PUSH.
- Driver 3 sends destination 8'h05 (drvrs=4):
  - push stays 0.
  - drop_cnt becomes 1.
  - After 260 such words, drop_cnt reads 8'hFF.
- reset pulsed during POP:
  - Next cycle, state is IDLE with pop=push=0.
  - rr_ptr=0, and the next grant goes to the lowest pending driver.
- Driver 0 deasserts pndng during PUSH while driver 3 is pending: the current push completes, then driver 3 is granted next.
